// File: rtl/pipe_rx_param_decoder.sv
// pipe_rx_param_decoder
//   Frames and checksums 16-bit words arriving from the host pipe-in FIFO into
//   per-channel parameter writes. A packet is a header (sync/nwords/chan/id),
//   1..3 data words (MSW first) and an XOR checksum word. id 0x3F is a commit
//   packet that pulses module_update_out instead of writing a parameter.
//
// Ports
//   clk50_in          system clock
//   reset_n_in        asynchronous active-low reset
//   word_valid_in     word available from rx FIFO
//   word_data_in      rx word
//   word_ready_out    word accepted when valid && ready (low in EMIT and reset)
//   param_wr_out      one-cycle parameter write strobe
//   param_id_out      id of last accepted write
//   param_chan_out    channel of last accepted write
//   param_data_out    assembled data, zero-extended, MSW first
//   chan_sel_out      one-hot of param_chan_out, held with it
//   module_update_out one-cycle strobe on a commit packet
//   pkt_count_out     accepted packets, wraps
//   err_count_out     rejected packets/words, saturates
//   busy_out          high in any state but IDLE
module pipe_rx_param_decoder #(
    parameter int N_CH    = 8,
    parameter int W_DATA  = 48,
    parameter int TIMEOUT = 1024,
    parameter int W_ERR   = 8
) (
    input  logic              clk50_in,
    input  logic              reset_n_in,
    input  logic              word_valid_in,
    input  logic [15:0]       word_data_in,
    output logic              word_ready_out,
    output logic              param_wr_out,
    output logic [5:0]        param_id_out,
    output logic [3:0]        param_chan_out,
    output logic [W_DATA-1:0] param_data_out,
    output logic [N_CH-1:0]   chan_sel_out,
    output logic              module_update_out,
    output logic [15:0]       pkt_count_out,
    output logic [W_ERR-1:0]  err_count_out,
    output logic              busy_out
);

    localparam int W_IDLE = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_CHECK,
        S_EMIT
    } state_t;

    state_t state, state_nxt;

    logic              ready_en;
    logic              accept;
    logic              hdr_ok;
    logic              csum_ok;
    logic              chan_ok;
    logic              timed_out;
    logic              err_inc;
    logic [1:0]        nwords;
    logic [1:0]        dcnt;
    logic [3:0]        chan;
    logic [5:0]        id;
    logic [W_DATA-1:0] acc;
    logic [15:0]       csum;
    logic [W_IDLE-1:0] idle_cnt;

    // ready_en keeps ready low while reset is held so every output reads 0.
    assign word_ready_out = ready_en && (state != S_EMIT);
    assign accept         = word_valid_in && word_ready_out;
    assign busy_out       = (state != S_IDLE);

    assign hdr_ok    = (word_data_in[15:12] == 4'hA) && (word_data_in[11:10] != 2'd0);
    assign csum_ok   = (word_data_in == csum);
    assign chan_ok   = ({28'd0, chan} < 32'(N_CH));
    // Fires on the TIMEOUT-th consecutive cycle without an accepted word.
    assign timed_out = !accept && (idle_cnt == W_IDLE'(TIMEOUT - 1));

    always_ff @(posedge clk50_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (hdr_ok) begin
                        state_nxt = S_DATA;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (dcnt == nwords - 2'd1) begin
                        state_nxt = S_CHECK;
                    end
                end else if (timed_out) begin
                    state_nxt = S_IDLE;
                    err_inc   = 1'b1;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (csum_ok && chan_ok) begin
                        state_nxt = S_EMIT;
                    end else begin
                        state_nxt = S_IDLE;
                        err_inc   = 1'b1;
                    end
                end else if (timed_out) begin
                    state_nxt = S_IDLE;
                    err_inc   = 1'b1;
                end
            end
            S_EMIT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            ready_en          <= 1'b0;
            nwords            <= '0;
            dcnt              <= '0;
            chan              <= '0;
            id                <= '0;
            acc               <= '0;
            csum              <= '0;
            idle_cnt          <= '0;
            param_wr_out      <= 1'b0;
            param_id_out      <= '0;
            param_chan_out    <= '0;
            param_data_out    <= '0;
            chan_sel_out      <= '0;
            module_update_out <= 1'b0;
            pkt_count_out     <= '0;
            err_count_out     <= '0;
        end else begin
            ready_en          <= 1'b1;
            param_wr_out      <= 1'b0;
            module_update_out <= 1'b0;

            if (err_inc && (err_count_out != '1)) begin
                err_count_out <= err_count_out + W_ERR'(1);
            end

            if ((state == S_DATA || state == S_CHECK) && !accept) begin
                idle_cnt <= idle_cnt + W_IDLE'(1);
            end else begin
                idle_cnt <= '0;
            end

            if (state == S_IDLE && accept && hdr_ok) begin
                nwords <= word_data_in[11:10];
                chan   <= word_data_in[9:6];
                id     <= word_data_in[5:0];
                csum   <= word_data_in;
                acc    <= '0;
                dcnt   <= '0;
            end

            if (state == S_DATA && accept) begin
                acc  <= {acc[W_DATA-17:0], word_data_in};
                csum <= csum ^ word_data_in;
                dcnt <= dcnt + 2'd1;
            end

            // Strobes are registered on the checksum-accept edge so they are
            // visible exactly during the EMIT cycle.
            if (state == S_CHECK && state_nxt == S_EMIT) begin
                pkt_count_out <= pkt_count_out + 16'd1;
                if (id == 6'h3F) begin
                    module_update_out <= 1'b1;
                end else begin
                    param_wr_out   <= 1'b1;
                    param_id_out   <= id;
                    param_chan_out <= chan;
                    param_data_out <= acc;
                    chan_sel_out   <= N_CH'(1) << chan;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_rx_param_decoder.sv
// Directed table plus hand sequences and a random scoreboard run for
// pipe_rx_param_decoder.
module tb_pipe_rx_param_decoder;

    localparam int N_CH    = 8;
    localparam int W_DATA  = 48;
    localparam int TIMEOUT = 1024;
    localparam int W_ERR   = 8;

    logic              clk50_in = 1'b0;
    logic              reset_n_in;
    logic              word_valid_in;
    logic [15:0]       word_data_in;
    logic              word_ready_out;
    logic              param_wr_out;
    logic [5:0]        param_id_out;
    logic [3:0]        param_chan_out;
    logic [W_DATA-1:0] param_data_out;
    logic [N_CH-1:0]   chan_sel_out;
    logic              module_update_out;
    logic [15:0]       pkt_count_out;
    logic [W_ERR-1:0]  err_count_out;
    logic              busy_out;

    pipe_rx_param_decoder #(
        .N_CH   (N_CH),
        .W_DATA (W_DATA),
        .TIMEOUT(TIMEOUT),
        .W_ERR  (W_ERR)
    ) dut (
        .clk50_in         (clk50_in),
        .reset_n_in       (reset_n_in),
        .word_valid_in    (word_valid_in),
        .word_data_in     (word_data_in),
        .word_ready_out   (word_ready_out),
        .param_wr_out     (param_wr_out),
        .param_id_out     (param_id_out),
        .param_chan_out   (param_chan_out),
        .param_data_out   (param_data_out),
        .chan_sel_out     (chan_sel_out),
        .module_update_out(module_update_out),
        .pkt_count_out    (pkt_count_out),
        .err_count_out    (err_count_out),
        .busy_out         (busy_out)
    );

    always #10 clk50_in = ~clk50_in;

    typedef struct {
        int unsigned      n;
        logic [4:0][15:0] w;
        logic             wr;
        logic             upd;
        logic [5:0]       id;
        logic [3:0]       chan;
        logic [47:0]      data;
        logic [7:0]       sel;
        logic [15:0]      pkt;
        logic [7:0]       err;
    } vec_t;

    vec_t vt [9];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input int unsigned n,
                           input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                           input logic [15:0] w3, input logic [15:0] w4,
                           input logic wr, input logic upd, input logic [5:0] id,
                           input logic [3:0] chan, input logic [47:0] data,
                           input logic [7:0] sel, input logic [15:0] pkt, input logic [7:0] err);
        vt[idx].n    = n;
        vt[idx].w[0] = w0;
        vt[idx].w[1] = w1;
        vt[idx].w[2] = w2;
        vt[idx].w[3] = w3;
        vt[idx].w[4] = w4;
        vt[idx].wr   = wr;
        vt[idx].upd  = upd;
        vt[idx].id   = id;
        vt[idx].chan = chan;
        vt[idx].data = data;
        vt[idx].sel  = sel;
        vt[idx].pkt  = pkt;
        vt[idx].err  = err;
    endtask

    // Called at posedge+1; presents a word and returns at posedge+1 after acceptance.
    task automatic send_word(input logic [15:0] w);
        int n;
        n = 0;
        word_valid_in = 1'b1;
        word_data_in  = w;
        while (!word_ready_out && n < 8) begin
            @(posedge clk50_in); #1;
            n++;
        end
        check("ready_before_word", 64'(word_ready_out), 64'(1));
        @(posedge clk50_in); #1;
    endtask

    task automatic idle_cycles(input int unsigned g);
        word_valid_in = 1'b0;
        word_data_in  = 16'($urandom);
        repeat (g) begin
            @(posedge clk50_in); #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(word_ready_out), 64'(0));
        check({tag, "_wr"},    64'(param_wr_out), 64'(0));
        check({tag, "_upd"},   64'(module_update_out), 64'(0));
        check({tag, "_id"},    64'(param_id_out), 64'(0));
        check({tag, "_chan"},  64'(param_chan_out), 64'(0));
        check({tag, "_data"},  64'(param_data_out), 64'(0));
        check({tag, "_sel"},   64'(chan_sel_out), 64'(0));
        check({tag, "_pkt"},   64'(pkt_count_out), 64'(0));
        check({tag, "_err"},   64'(err_count_out), 64'(0));
        check({tag, "_busy"},  64'(busy_out), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  m_id;
        logic [3:0]  m_chan;
        logic [47:0] m_data;
        logic [7:0]  m_sel;
        logic [15:0] exp_pkt;
        logic [15:0] hdr, cs, dw;
        logic [47:0] d;
        int unsigned nw, ch;
        logic [5:0]  rid;

        //  n  words                                    wr upd id    ch  data               sel    pkt err
        set_vec(0, 3, 16'hA485, 16'h1234, 16'hB6B1, 16'h0, 16'h0,
                1, 0, 6'h05, 4'd2, 48'h0000_0000_1234, 8'h04, 16'd1, 8'd0);
        set_vec(1, 5, 16'hAC0B, 16'h0001, 16'h0002, 16'h0003, 16'hAC0B,
                1, 0, 6'h0B, 4'd0, 48'h0001_0002_0003, 8'h01, 16'd2, 8'd0);
        set_vec(2, 3, 16'hA43F, 16'h0000, 16'hA43F, 16'h0, 16'h0,
                0, 1, 6'h0B, 4'd0, 48'h0001_0002_0003, 8'h01, 16'd3, 8'd0);
        set_vec(3, 1, 16'h5485, 16'h0, 16'h0, 16'h0, 16'h0,
                0, 0, 6'h0B, 4'd0, 48'h0001_0002_0003, 8'h01, 16'd3, 8'd1);
        set_vec(4, 3, 16'hA485, 16'h1234, 16'hB6B1, 16'h0, 16'h0,
                1, 0, 6'h05, 4'd2, 48'h0000_0000_1234, 8'h04, 16'd4, 8'd1);
        set_vec(5, 3, 16'hA485, 16'h1234, 16'hB6B0, 16'h0, 16'h0,
                0, 0, 6'h05, 4'd2, 48'h0000_0000_1234, 8'h04, 16'd4, 8'd2);
        set_vec(6, 3, 16'hA647, 16'h0055, 16'hA612, 16'h0, 16'h0,
                0, 0, 6'h05, 4'd2, 48'h0000_0000_1234, 8'h04, 16'd4, 8'd3);
        set_vec(7, 4, 16'hA9EA, 16'hDEAD, 16'hBEEF, 16'hC9A8, 16'h0,
                1, 0, 6'h2A, 4'd7, 48'h0000_DEAD_BEEF, 8'h80, 16'd5, 8'd3);
        set_vec(8, 1, 16'hA005, 16'h0, 16'h0, 16'h0, 16'h0,
                0, 0, 6'h2A, 4'd7, 48'h0000_DEAD_BEEF, 8'h80, 16'd5, 8'd4);

        reset_n_in    = 1'b0;
        word_valid_in = 1'b0;
        word_data_in  = '0;
        repeat (3) @(posedge clk50_in);
        #1;
        check_all_zero("reset");
        reset_n_in = 1'b1;
        repeat (2) @(posedge clk50_in);
        #1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            for (int unsigned k = 0; k < vt[i].n; k++) send_word(vt[i].w[k]);
            word_valid_in = 1'b0;
            check($sformatf("v%0d_wr", i),   64'(param_wr_out), 64'(vt[i].wr));
            check($sformatf("v%0d_upd", i),  64'(module_update_out), 64'(vt[i].upd));
            check($sformatf("v%0d_id", i),   64'(param_id_out), 64'(vt[i].id));
            check($sformatf("v%0d_chan", i), 64'(param_chan_out), 64'(vt[i].chan));
            check($sformatf("v%0d_data", i), 64'(param_data_out), 64'(vt[i].data));
            check($sformatf("v%0d_sel", i),  64'(chan_sel_out), 64'(vt[i].sel));
            check($sformatf("v%0d_pkt", i),  64'(pkt_count_out), 64'(vt[i].pkt));
            check($sformatf("v%0d_err", i),  64'(err_count_out), 64'(vt[i].err));
            @(posedge clk50_in); #1;
            check($sformatf("v%0d_wr_pulse", i),  64'(param_wr_out), 64'(0));
            check($sformatf("v%0d_upd_pulse", i), 64'(module_update_out), 64'(0));
            check($sformatf("v%0d_busy", i),      64'(busy_out), 64'(0));
        end

        // Timeout: header then stall
        send_word(16'hA485);
        idle_cycles(TIMEOUT - 10);
        check("to_busy_before", 64'(busy_out), 64'(1));
        idle_cycles(15);
        check("to_busy_after", 64'(busy_out), 64'(0));
        check("to_err", 64'(err_count_out), 64'(5));
        send_word(16'hA485);
        send_word(16'h1234);
        send_word(16'hB6B1);
        word_valid_in = 1'b0;
        check("to_recover_wr", 64'(param_wr_out), 64'(1));
        check("to_recover_pkt", 64'(pkt_count_out), 64'(6));
        @(posedge clk50_in); #1;

        // Reset mid-DATA
        send_word(16'hAC0B);
        send_word(16'h1111);
        word_valid_in = 1'b0;
        check("mid_busy", 64'(busy_out), 64'(1));
        reset_n_in = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk50_in); #1;
        reset_n_in = 1'b1;
        @(posedge clk50_in); #1;
        check("post_reset_wr", 64'(param_wr_out), 64'(0));

        // Random valid packets against a scoreboard
        m_id = '0; m_chan = '0; m_data = '0; m_sel = '0; exp_pkt = '0;
        for (int p = 0; p < 1000; p++) begin
            nw  = $urandom_range(1, 3);
            ch  = $urandom_range(0, N_CH - 1);
            rid = ($urandom_range(0, 15) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
            hdr = {4'hA, 2'(nw), 4'(ch), rid};
            cs  = hdr;
            d   = '0;
            send_word(hdr);
            for (int unsigned k = 0; k < nw; k++) begin
                idle_cycles($urandom_range(0, 3));
                dw = 16'($urandom);
                send_word(dw);
                cs = cs ^ dw;
                d  = {d[31:0], dw};
            end
            idle_cycles($urandom_range(0, 3));
            send_word(cs);
            word_valid_in = 1'b0;
            exp_pkt = exp_pkt + 16'd1;
            if (rid != 6'h3F) begin
                m_id   = rid;
                m_chan = 4'(ch);
                m_data = d;
                m_sel  = 8'(1) << ch;
            end
            check("rnd_wr",    64'(param_wr_out), 64'(rid != 6'h3F));
            check("rnd_upd",   64'(module_update_out), 64'(rid == 6'h3F));
            check("rnd_id",    64'(param_id_out), 64'(m_id));
            check("rnd_chan",  64'(param_chan_out), 64'(m_chan));
            check("rnd_data",  64'(param_data_out), 64'(m_data));
            check("rnd_sel",   64'(chan_sel_out), 64'(m_sel));
            check("rnd_ready_emit", 64'(word_ready_out), 64'(0));
            @(posedge clk50_in); #1;
        end
        check("rnd_pkt", 64'(pkt_count_out), 64'(16'd1000));
        check("rnd_err", 64'(err_count_out), 64'(0));

        // Error counter saturation
        for (int i = 0; i < 300; i++) send_word(16'h5485);
        word_valid_in = 1'b0;
        @(posedge clk50_in); #1;
        check("sat_err", 64'(err_count_out), 64'(8'hFF));
        check("sat_pkt", 64'(pkt_count_out), 64'(16'd1000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_rx_param_decoder.md
Name: pipe_rx_param_decoder

Overview:
- Host-to-FPGA bulk parameter path and the receive counterpart of the pipe-out transmit path.
- The host streams 16-bit words through an okPipeIn. A CDC FIFO delivers those words into the clk50_in domain, and this block frames and checksums them into per-channel parameter writes.
- Accepted packets drive the osf, pid, rtr and opp parameter registers. A commit packet raises module_update_out, replacing per-register wire-in polling.

Parameters:
N_CH, 8, number of addressable channels (one-hot select width)
W_DATA, 48, width of assembled parameter data (3 words max)
TIMEOUT, 1024, idle cycles allowed between words inside a packet
W_ERR, 8, width of saturating error counter

Ports:
clk50_in  input  1  system clock
reset_n_in  input  1  asynchronous active-low reset
word_valid_in  input  1  word available from rx FIFO
word_data_in  input  16  rx word
word_ready_out  output  1  word accepted when valid&&ready
param_wr_out  output  1  one-cycle strobe, parameter write
param_id_out  output  6  parameter id of last accepted write
param_chan_out  output  4  channel index of last accepted write
param_data_out  output  W_DATA  assembled data, zero-extended, MSW first
chan_sel_out  output  N_CH  one-hot of param_chan_out, valid with strobe
module_update_out  output  1  one-cycle strobe on commit packet
pkt_count_out  output  16  accepted packets, wraps
err_count_out  output  W_ERR  rejected packets/words, saturates at all-ones
busy_out  output  1  high in any state but IDLE

Behaviour:
- Interface decision: one clock, clk50_in. Reset reset_n_in is asynchronous and active-low.
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-packet discards the partial packet with no strobe.
- Packet format: header, then nwords data words, then a checksum word.
  - Header [15:12] is sync, must be 0xA.
  - Header [11:10] is nwords, 1..3.
  - Header [9:6] is chan.
  - Header [5:0] is id.
  - Checksum is the XOR of the header and all data words.
- FSM states: IDLE, DATA, CHECK, EMIT.
- IDLE:
  - ready=1.
  - On an accepted word with sync==0xA and nwords!=0: latch the header, clear the data accumulator, go to DATA.
  - Otherwise drop the word, err_count+1, stay IDLE.
- DATA:
  - ready=1.
  - Each accepted word does acc = {acc[W_DATA-17:0], word} and XORs into the running checksum.
  - After nwords words, go to CHECK.
- CHECK:
  - ready=1.
  - On an accepted word, compare it with the running checksum and register the result.
  - Go to EMIT when the checksum matches and chan<N_CH.
  - Otherwise err_count+1 and go to IDLE.
- EMIT:
  - ready=0 for exactly one cycle, then IDLE.
  - If id==0x3F, pulse module_update_out only. param_* outputs and param_wr_out are unchanged.
  - Otherwise update param_id/chan/data/chan_sel and pulse param_wr_out.
  - pkt_count+1 in both cases.
- Latency: the checksum word accepted on cycle t produces its strobe on t+1. The next header can be accepted on t+2 at the earliest.
- Timeout:
  - In DATA or CHECK, an idle counter counts cycles without an accepted word. It resets on each accepted word.
  - Reaching TIMEOUT aborts to IDLE with err_count+1.
- param_* outputs hold between strobes. chan_sel_out is one-hot and is held with them.
- err_count saturates and does not wrap. pkt_count wraps from 0xFFFF to 0.
- word_valid_in deasserting mid-packet is legal; only the timeout rule applies.

Test Plan:
- Single-word write: send 0xA485, 0x1234, 0xB6B1 back-to-back. Expect param_wr_out high one cycle after the third word, with id=0x05, chan=2, data=0x000000001234 and chan_sel=0x04. pkt_count=1.
- Three-word write: send 0xAC0B, 0x0001, 0x0002, 0x0003, 0xAC0B. Expect data=0x000100020003, id=0x0B, chan=0.
- Commit: send 0xA43F, 0x0000, 0xA43F. Expect a module_update_out pulse with no param_wr_out and param_* unchanged. pkt_count increments.
- Corruption:
  - Header 0x5485 expects err_count=1 and a resync on a following valid packet.
  - Checksum 0xB6B0 expects no strobe and err_count+1.
  - Header chan=9 (N_CH=8) expects rejection.
- Timeout and reset: send 0xA485, then stall TIMEOUT cycles. Expect busy_out to fall and err_count+1. A subsequent valid packet must succeed. Assert reset_n_in low mid-DATA and expect no strobe and all outputs 0.
- Throughput and saturation:
  - 1000 random valid packets with random valid gaps: every strobe matches the scoreboard, ready is low only in EMIT, and pkt_count=1000.
  - 300 bad headers: err_count stays at 255.
